stm32_bus_master: RTL

- Initiator end of the 8-bit DATA_BUS/DATA_SYNC parameter and IQ link. Drives a command byte with DATA_SYNC, then streams a fixed number of bytes to the responder, or samples bytes from it, one byte per clk_in.
- Used as the FPGA-side master for board-to-board links and for loopback self-test against the transceiver's bus responder.
- Byte counts and command codes come from the requesting logic. The block only enforces bus timing and direction.

---
 rtl/stm32_bus_master.sv | 177 +++++++++++++++++
 1 files changed

// File: rtl/stm32_bus_master.sv
// Initiator for the 8-bit DATA_BUS/DATA_SYNC link: command byte with SYNC, then a fixed-length
// write or read data phase. Optional statistics counters are enabled with BUSM_STATS_EN.
module stm32_bus_master #(
   parameter int unsigned LEN_W  = 8,
   parameter int unsigned RD_LAT = 2
) (
`ifdef BUSM_STATS_EN
   input  logic              stats_clr,
   output logic [15:0]       txn_count,
   output logic [23:0]       byte_count,
`endif
   input  logic              clk_in,
   input  logic              reset_n,
   input  logic              cmd_valid,
   output logic              cmd_ready,
   input  logic [7:0]        cmd_code,
   input  logic              cmd_read,
   input  logic [LEN_W-1:0]  cmd_len,
   input  logic [7:0]        wr_data,
   input  logic              wr_valid,
   output logic              wr_ready,
   output logic [7:0]        rd_data,
   output logic              rd_valid,
   output logic              busy,
   output logic              wr_underrun,
   output logic              DATA_SYNC,
   inout  wire  [7:0]        DATA_BUS
);

   localparam int unsigned CNT_W = LEN_W + 1;

   typedef enum logic [2:0] {S_IDLE, S_SYNC, S_WRITE, S_READ, S_TURN} state_t;

   state_t           r_state;
   state_t           w_state_nxt;
   logic [7:0]       r_code;
   logic             r_read;
   logic [LEN_W-1:0] r_len;
   logic [CNT_W-1:0] r_cnt;
   logic [7:0]       r_wbyte;
   logic             r_underrun;
   logic [7:0]       r_rd_data;
   logic             r_rd_valid;

   logic             w_accept;
   logic             w_load;
   logic             w_wr_last;
   logic             w_rd_last;
   logic             w_rd_sample;
   logic             w_len_zero;
   logic             w_end;
   logic             w_oe;
   logic [7:0]       w_bus_out;
   logic [CNT_W-1:0] w_len_ext;

   assign w_len_ext   = CNT_W'(r_len);
   assign w_len_zero  = (r_len == '0);
   assign w_accept    = cmd_valid && (r_state == S_IDLE);
   assign w_wr_last   = (r_cnt == w_len_ext - CNT_W'(1));
   assign w_rd_last   = (r_cnt == w_len_ext + CNT_W'(RD_LAT) - CNT_W'(2));
   assign w_rd_sample = (r_state == S_READ) && (r_cnt >= CNT_W'(RD_LAT - 1));
   // A write byte is fetched at the edge before the cycle that drives it
   assign w_load      = ((r_state == S_SYNC) && !r_read && !w_len_zero) ||
                        ((r_state == S_WRITE) && !w_wr_last);
   assign w_end       = ((r_state == S_SYNC) && w_len_zero) ||
                        ((r_state == S_WRITE) && w_wr_last) ||
                        (r_state == S_TURN);

   // State register
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Next-state logic
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:  if (cmd_valid) w_state_nxt = S_SYNC;
         S_SYNC: begin
            if (w_len_zero)  w_state_nxt = S_IDLE;
            else if (r_read) w_state_nxt = S_READ;
            else             w_state_nxt = S_WRITE;
         end
         S_WRITE: if (w_wr_last) w_state_nxt = S_IDLE;
         // Responder keeps driving after a read, so hold one released cycle before idling
         S_READ:  if (w_rd_last) w_state_nxt = S_TURN;
         S_TURN:  w_state_nxt = S_IDLE;
         default: w_state_nxt = S_IDLE;
      endcase
   end

   // Output decode
   always_comb begin
      cmd_ready = 1'b0;
      busy      = 1'b1;
      DATA_SYNC = 1'b0;
      w_oe      = 1'b0;
      w_bus_out = r_wbyte;
      case (r_state)
         S_IDLE: begin
            cmd_ready = 1'b1;
            busy      = cmd_valid;
         end
         S_SYNC: begin
            DATA_SYNC = 1'b1;
            w_oe      = 1'b1;
            w_bus_out = r_code;
         end
         S_WRITE: w_oe = 1'b1;
         default: ;
      endcase
   end

   assign DATA_BUS    = w_oe ? w_bus_out : 8'hzz;
   assign wr_ready    = w_load;
   assign wr_underrun = r_underrun;
   assign rd_data     = r_rd_data;
   assign rd_valid    = r_rd_valid;

   // Command latch, byte counter, write/read datapath
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         r_code     <= 8'h00;
         r_read     <= 1'b0;
         r_len      <= '0;
         r_cnt      <= '0;
         r_wbyte    <= 8'h00;
         r_underrun <= 1'b0;
         r_rd_data  <= 8'h00;
         r_rd_valid <= 1'b0;
      end else begin
         if (w_accept) begin
            r_code     <= cmd_code;
            r_read     <= cmd_read;
            r_len      <= cmd_len;
            r_underrun <= 1'b0;
         end
         // The responder cannot stall, so a missing byte goes out as zero
         if (w_load) begin
            r_wbyte <= wr_valid ? wr_data : 8'h00;
            if (!wr_valid) r_underrun <= 1'b1;
         end
         case (r_state)
            S_WRITE, S_READ: r_cnt <= r_cnt + CNT_W'(1);
            default:         r_cnt <= '0;
         endcase
         r_rd_valid <= w_rd_sample;
         if (w_rd_sample) r_rd_data <= DATA_BUS;
      end
   end

`ifdef BUSM_STATS_EN
   logic [15:0] r_txn_count;
   logic [23:0] r_byte_count;
   logic [24:0] w_byte_sum;

   assign w_byte_sum = {1'b0, r_byte_count} + 25'(r_len);
   assign txn_count  = r_txn_count;
   assign byte_count = r_byte_count;

   // Transaction/byte statistics; clear has priority over a same-cycle update
   always_ff @(posedge clk_in or negedge reset_n) begin
      if (!reset_n) begin
         r_txn_count  <= 16'h0000;
         r_byte_count <= 24'h000000;
      end else if (stats_clr) begin
         r_txn_count  <= 16'h0000;
         r_byte_count <= 24'h000000;
      end else if (w_end) begin
         r_txn_count  <= r_txn_count + 16'd1;
         r_byte_count <= w_byte_sum[24] ? 24'hFFFFFF : w_byte_sum[23:0];
      end
   end
`endif

endmodule
